data_memory: RTL and testbench

Byte-addressable data memory for the single-cycle MIPS datapath, sitting directly downstream of the ALU. It takes the ALU result as the effective address and register rt as store data. It performs word, halfword and byte stores on the clock edge, and returns sign- or zero-extended loads combinationally within the same cycle. It flags misaligned and out-of-range accesses and suppresses their side effects.

---
 rtl/data_memory.sv | 106 ++++++++++
 tb/tb_data_memory.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the single-cycle MIPS datapath.
// Stores commit on the rising edge; loads and fault flags are combinational.
module data_memory #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        out_of_range
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic          w_active;
    logic          w_fault;
    logic          w_store;
    logic          w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_word;
    logic [31:0]   w_shift;

    assign w_idx    = addr[AW+1:2];
    assign w_active = mem_read | mem_write;

    // Upper address bits must be clear; no wrap back onto low words.
    assign out_of_range = w_active & (|addr[31:AW+2]);

    always_comb begin
        misaligned = 1'b0;
        if (w_active) begin
            case (mem_size)
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = addr[0];
                2'b10:   misaligned = |addr[1:0];
                default: misaligned = 1'b1;
            endcase
        end
    end

    assign w_fault = misaligned | out_of_range;
    assign w_store = mem_write & ~w_fault;
    assign w_load  = mem_read & ~w_fault;

    // Replicate sub-word data across lanes so each lane only needs its enable.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = write_data;
        case (mem_size)
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_data[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = write_data;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = write_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {addr[1:0], 3'b000};

    always_comb begin
        read_data = '0;
        if (w_load) begin
            case (mem_size)
                2'b00:   read_data = {{24{~mem_unsigned & w_shift[7]}}, w_shift[7:0]};
                2'b01:   read_data = {{16{~mem_unsigned & w_shift[15]}}, w_shift[15:0]};
                2'b10:   read_data = w_word;
                default: read_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized
// traffic checked against a byte-array reference model.
module tb_data_memory;
    localparam int DEPTH = 256;
    localparam int NBYTES = DEPTH * 4;

    logic        clk;
    logic        rst;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        misaligned;
    logic        out_of_range;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [NBYTES];

    data_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .addr         (addr),
        .write_data   (write_data),
        .read_data    (read_data),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic exp_mis(logic rd, logic wr, logic [1:0] sz, logic [31:0] a);
        if (!(rd || wr)) return 1'b0;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic exp_oor(logic rd, logic wr, logic [31:0] a);
        return (rd || wr) && (a >= NBYTES);
    endfunction

    function automatic logic [31:0] exp_rd(logic rd, logic wr, logic [1:0] sz, logic u,
                                           logic [31:0] a);
        logic [31:0] v;
        if (!rd || exp_mis(rd, wr, sz, a) || exp_oor(rd, wr, a)) return 32'h0;
        case (sz)
            2'd0: begin
                v = {24'h0, ref_mem[a]};
                if (!u && v[7]) v = v - 32'd256;
            end
            2'd1: begin
                v = {16'h0, ref_mem[a+1], ref_mem[a]};
                if (!u && v[15]) v = v - 32'd65536;
            end
            default: v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        endcase
        return v;
    endfunction

    task automatic model_edge();
        int n;
        logic [31:0] d;
        if (rst) begin
            for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
        end else if (mem_write && !exp_mis(mem_read, mem_write, mem_size, addr)
                     && !exp_oor(mem_read, mem_write, addr)) begin
            n = 1 << mem_size;
            d = write_data;
            for (int k = 0; k < n; k++) begin
                ref_mem[addr + k] = d[7:0];
                d = d >> 8;
            end
        end
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(logic wr, logic rd, logic [1:0] sz, logic u, logic [31:0] a,
                         logic [31:0] wd);
        mem_write = wr; mem_read = rd; mem_size = sz; mem_unsigned = u;
        addr = a; write_data = wd;
        #1;
    endtask

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic store(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        drive(1'b1, 1'b0, sz, 1'b0, a, wd);
        clk_edge();
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        total++;
        if (read_data !== 32'h0 || misaligned !== 1'b0 || out_of_range !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle rd=%h mis=%b oor=%b want 0/0/0", read_data, misaligned, out_of_range);
        end
        clk_edge();
        rst = 1'b0;
        store(2'd2, 32'h10, 32'hDEADBEEF);
        rst = 1'b1;
        clk_edge();
        rst = 1'b0;
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
        total++;
        if (read_data !== 32'h0 || misaligned !== 1'b0 || out_of_range !== 1'b0) begin
            bad++;
            $display("FAIL reset_clear rd=%h mis=%b oor=%b want 0/0/0", read_data, misaligned, out_of_range);
        end
    endtask

    task automatic test_subword();
        store(2'd2, 32'h20, 32'h00000000);
        store(2'd0, 32'h21, 32'hABCDEF80);
        store(2'd1, 32'h22, 32'h1234FFFE);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
        total++;
        if (read_data !== 32'hFFFE8000) begin
            bad++; $display("FAIL lw_20 got=%h want=FFFE8000", read_data);
        end
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0);
        total++;
        if (read_data !== 32'hFFFFFF80) begin
            bad++; $display("FAIL lb_21 got=%h want=FFFFFF80", read_data);
        end
        drive(1'b0, 1'b1, 2'd0, 1'b1, 32'h21, 32'h0);
        total++;
        if (read_data !== 32'h00000080) begin
            bad++; $display("FAIL lbu_21 got=%h want=00000080", read_data);
        end
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0);
        total++;
        if (read_data !== 32'hFFFFFFFE) begin
            bad++; $display("FAIL lh_22 got=%h want=FFFFFFFE", read_data);
        end
        drive(1'b0, 1'b1, 2'd1, 1'b1, 32'h22, 32'h0);
        total++;
        if (read_data !== 32'h0000FFFE) begin
            bad++; $display("FAIL lhu_22 got=%h want=0000FFFE", read_data);
        end
    endtask

    task automatic test_back_to_back();
        store(2'd2, 32'h70, 32'h0);
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h70, 32'h000000A5);
        clk_edge();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h73, 32'h0000005A);
        clk_edge();
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h70, 32'h0);
        total++;
        if (read_data !== 32'h5A0000A5) begin
            bad++; $display("FAIL b2b_accum got=%h want=5A0000A5", read_data);
        end
    endtask

    task automatic test_misaligned();
        store(2'd2, 32'h30, 32'hCAFEF00D);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h31, 32'h12345678);
        total++;
        if (misaligned !== 1'b1) begin
            bad++; $display("FAIL sw_31_mis got=%b want=1", misaligned);
        end
        clk_edge();
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0);
        total++;
        if (read_data !== 32'hCAFEF00D) begin
            bad++; $display("FAIL word_30_kept got=%h want=CAFEF00D", read_data);
        end
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h33, 32'h0);
        total++;
        if (misaligned !== 1'b1 || read_data !== 32'h0) begin
            bad++; $display("FAIL lh_33 mis=%b rd=%h want 1/0", misaligned, read_data);
        end
        drive(1'b0, 1'b1, 2'd3, 1'b0, 32'h40, 32'h0);
        total++;
        if (misaligned !== 1'b1 || read_data !== 32'h0) begin
            bad++; $display("FAIL size11_40 mis=%b rd=%h want 1/0", misaligned, read_data);
        end
    endtask

    task automatic test_out_of_range();
        store(2'd2, 32'h000, 32'h13572468);
        store(2'd2, 32'h3FC, 32'h0BADCAFE);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'hAAAAAAAA);
        total++;
        if (out_of_range !== 1'b1 || misaligned !== 1'b0) begin
            bad++; $display("FAIL sw_400_oor oor=%b mis=%b want 1/0", out_of_range, misaligned);
        end
        clk_edge();
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h000, 32'h0);
        total++;
        if (read_data !== 32'h13572468) begin
            bad++; $display("FAIL no_alias_0 got=%h want=13572468", read_data);
        end
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h3FC, 32'h0);
        total++;
        if (out_of_range !== 1'b0 || read_data !== 32'h0BADCAFE) begin
            bad++; $display("FAIL lw_3FC oor=%b rd=%h want 0/0BADCAFE", out_of_range, read_data);
        end
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h8000_0000, 32'h0);
        total++;
        if (out_of_range !== 1'b1 || read_data !== 32'h0) begin
            bad++; $display("FAIL lb_high oor=%b rd=%h want 1/0", out_of_range, read_data);
        end
    endtask

    task automatic test_rdw();
        store(2'd2, 32'h50, 32'h11111111);
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h50, 32'h22222222);
        total++;
        if (read_data !== 32'h11111111) begin
            bad++; $display("FAIL rdw_old got=%h want=11111111", read_data);
        end
        clk_edge();
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h50, 32'h0);
        total++;
        if (read_data !== 32'h22222222) begin
            bad++; $display("FAIL rdw_new got=%h want=22222222", read_data);
        end
    endtask

    task automatic test_reset_priority();
        store(2'd2, 32'h64, 32'h77777777);
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h60, 32'h55555555);
        clk_edge();
        rst = 1'b0;
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h60, 32'h0);
        total++;
        if (read_data !== 32'h0) begin
            bad++; $display("FAIL rst_prio_60 got=%h want=00000000", read_data);
        end
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h64, 32'h0);
        total++;
        if (read_data !== 32'h0) begin
            bad++; $display("FAIL rst_prio_64 got=%h want=00000000", read_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, e_rd;
        logic [1:0]  sz;
        logic        wr, rd, u, e_mis, e_oor;
        int          r;
        for (int it = 0; it < 400; it++) begin
            r  = $urandom_range(0, 9);
            a  = (r == 0) ? $urandom() : 32'($urandom_range(0, 127));
            r  = $urandom_range(0, 7);
            sz = (r == 7) ? 2'd3 : 2'(r % 3);
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 59) == 0);
            drive(wr, rd, sz, u, a, $urandom());
            e_rd  = exp_rd(rd, wr, sz, u, a);
            e_mis = exp_mis(rd, wr, sz, a);
            e_oor = exp_oor(rd, wr, a);
            total++;
            if (read_data !== e_rd) begin
                bad++;
                $display("FAIL rand_rd it=%0d a=%h sz=%0d u=%b got=%h want=%h", it, a, sz, u, read_data, e_rd);
            end
            total++;
            if (misaligned !== e_mis) begin
                bad++; $display("FAIL rand_mis it=%0d a=%h sz=%0d got=%b want=%b", it, a, sz, misaligned, e_mis);
            end
            total++;
            if (out_of_range !== e_oor) begin
                bad++; $display("FAIL rand_oor it=%0d a=%h got=%b want=%b", it, a, out_of_range, e_oor);
            end
            clk_edge();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        mem_write = 1'b0; mem_read = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0;
        addr = 32'h0; write_data = 32'h0;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_subword();
        test_back_to_back();
        test_misaligned();
        test_out_of_range();
        test_rdw();
        test_reset_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
